// File: rtl/scan_pkg.sv
// Shared types and helpers for the panel-side scan responder.
package scan_pkg;

    localparam int unsigned SCAN_N_SECT = 8;
    localparam int unsigned SCAN_DATA_W = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StHold   = 2'd2,
        StError  = 2'd3
    } scan_state_t;

    function automatic logic is_one_hot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [4:0] lowest_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One local switch: 2-flop synchronizer followed by a DEB_CNT-sample debouncer.
module switch_debounce #(
    parameter int unsigned DEB_CNT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable
);

    localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);

    logic             sw_s1_q;
    logic             sw_s2_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_s1_q   <= 1'b0;
            sw_s2_q   <= 1'b0;
            cnt_q     <= '0;
            sw_stable <= 1'b0;
        end else begin
            sw_s1_q <= sw_raw;
            sw_s2_q <= sw_s1_q;
            // Any agreeing sample restarts the run of disagreeing ones.
            if (sw_s2_q == sw_stable) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
                sw_stable <= sw_s2_q;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_responder.sv
// Panel-side scan responder: demultiplexes scanned section data and returns switch state.
// Define SCAN_RESP_DEBOUNCE_EN to debounce the local switches.
module scan_responder
    import scan_pkg::*;
#(
    parameter int unsigned N_SECT  = SCAN_N_SECT,
    parameter int unsigned DATA_W  = SCAN_DATA_W,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned DEB_CNT = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SECT-1:0]        selector,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [N_SECT-1:0]        switches,
    output logic                     data_switch,
    output logic [N_SECT*DATA_W-1:0] section_data,
    output logic [N_SECT-1:0]        valid_sections,
    output logic                     frame_done,
    output logic                     sel_error,
    output logic                     stale
);

    localparam int unsigned IDX_W  = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam int unsigned SCNT_W = $clog2(SETTLE + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    logic [N_SECT-1:0]              sel_s1_q, sel_s2_q, sel_prev_q;
    logic [DATA_W-1:0]              din_s1_q, din_s2_q;
    scan_state_t                    state_q;
    logic [SCNT_W-1:0]              scnt_q;
    logic [TCNT_W-1:0]              tcnt_q;
    logic [N_SECT-1:0][DATA_W-1:0]  sect_q;
    logic [N_SECT-1:0]              sw_deb;

    logic             sel_changed, sel_one_hot, settle_done, capture, multi_hot;
    logic [IDX_W-1:0] sel_idx;

`ifdef SCAN_RESP_DEBOUNCE_EN
    for (genvar i = 0; i < N_SECT; i++) begin : g_deb
        switch_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .sw_raw    (switches[i]),
            .sw_stable (sw_deb[i])
        );
    end
`else
    logic [N_SECT-1:0] sw_s1_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_s1_q <= '0;
            sw_deb  <= '0;
        end else begin
            sw_s1_q <= switches;
            sw_deb  <= sw_s1_q;
        end
    end
`endif

    always_comb begin
        sel_changed = (sel_s2_q != sel_prev_q);
        sel_one_hot = is_one_hot(32'(sel_s2_q));
        sel_idx     = IDX_W'(lowest_idx(32'(sel_s2_q)));
        // Counter was cleared on the change cycle, so this edge completes SETTLE stable cycles.
        settle_done = (state_q == StSettle) && (sel_s2_q != '0) && !sel_changed &&
                      ((scnt_q + 1'b1) == SCNT_W'(SETTLE - 1));
        capture     = settle_done && sel_one_hot;
        multi_hot   = settle_done && !sel_one_hot;
    end

    assign section_data = sect_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_s1_q       <= '0;
            sel_s2_q       <= '0;
            sel_prev_q     <= '0;
            din_s1_q       <= '0;
            din_s2_q       <= '0;
            state_q        <= StIdle;
            scnt_q         <= '0;
            tcnt_q         <= '0;
            sect_q         <= '0;
            valid_sections <= '0;
            frame_done     <= 1'b0;
            sel_error      <= 1'b0;
            stale          <= 1'b0;
            data_switch    <= 1'b0;
        end else begin
            sel_s1_q   <= selector;
            sel_s2_q   <= sel_s1_q;
            sel_prev_q <= sel_s2_q;
            din_s1_q   <= data_in;
            din_s2_q   <= din_s1_q;
            frame_done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (sel_s2_q != '0) begin
                        state_q <= StSettle;
                        scnt_q  <= '0;
                    end
                end
                StSettle: begin
                    if (sel_s2_q == '0) begin
                        state_q <= StIdle;
                    end else if (sel_changed) begin
                        scnt_q <= '0;
                    end else if (capture) begin
                        state_q <= StHold;
                    end else if (multi_hot) begin
                        state_q   <= StError;
                        sel_error <= 1'b1;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                StHold, StError: begin
                    if (sel_changed) begin
                        if (sel_s2_q == '0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StSettle;
                            scnt_q  <= '0;
                        end
                    end
                end
            endcase

            // A capture takes priority over a timeout landing on the same edge.
            if (capture) begin
                sect_q[sel_idx]         <= din_s2_q;
                valid_sections[sel_idx] <= 1'b1;
                sel_error               <= 1'b0;
                stale                   <= 1'b0;
                tcnt_q                  <= '0;
                frame_done <= (sel_idx == IDX_W'(N_SECT - 1)) && (&(valid_sections | sel_s2_q));
            end else if (tcnt_q >= TCNT_W'(TIMEOUT - 1)) begin
                tcnt_q         <= TCNT_W'(TIMEOUT);
                stale          <= 1'b1;
                valid_sections <= '0;
            end else begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            data_switch <= (sel_s2_q != '0) ? sw_deb[sel_idx] : 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_responder.sv
// Directed bench for scan_responder: sweep table plus glitch, multi-hot, bounce,
// timeout and reset sequences.
module tb_scan_responder;

    localparam int unsigned N_SECT  = 8;
    localparam int unsigned DATA_W  = 3;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned DEB_CNT = 16;
    localparam int unsigned TIMEOUT = 65535;
`ifdef SCAN_RESP_DEBOUNCE_EN
    localparam int unsigned DEB_LAT = DEB_CNT;
`else
    localparam int unsigned DEB_LAT = 0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_SECT-1:0]        selector;
    logic [DATA_W-1:0]        data_in;
    logic [N_SECT-1:0]        switches;
    logic                     data_switch;
    logic [N_SECT*DATA_W-1:0] section_data;
    logic [N_SECT-1:0]        valid_sections;
    logic                     frame_done;
    logic                     sel_error;
    logic                     stale;

    int errors = 0;
    int checks = 0;
    int frames = 0;

    typedef struct {
        logic [7:0]  sel;
        logic [2:0]  din;
        logic [7:0]  exp_valid;
        logic [23:0] exp_data;
    } vec_t;

    vec_t sweep [8];

    scan_responder #(
        .N_SECT  (N_SECT),
        .DATA_W  (DATA_W),
        .SETTLE  (SETTLE),
        .DEB_CNT (DEB_CNT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .selector       (selector),
        .data_in        (data_in),
        .switches       (switches),
        .data_switch    (data_switch),
        .section_data   (section_data),
        .valid_sections (valid_sections),
        .frame_done     (frame_done),
        .sel_error      (sel_error),
        .stale          (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n rising edges; outputs are sampled 1 time unit after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_done) frames++;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"}, 32'(section_data), 32'h0);
        check({name, "_valid"}, 32'(valid_sections), 32'h0);
        check({name, "_frame"}, 32'(frame_done), 32'h0);
        check({name, "_err"}, 32'(sel_error), 32'h0);
        check({name, "_stale"}, 32'(stale), 32'h0);
        check({name, "_dsw"}, 32'(data_switch), 32'h0);
    endtask

    initial begin
        int ones;
        int n;

        sweep[0] = '{8'h01, 3'd0, 8'h09, 24'h000C00};
        sweep[1] = '{8'h02, 3'd1, 8'h0B, 24'h000C08};
        sweep[2] = '{8'h04, 3'd2, 8'h0F, 24'h000C88};
        sweep[3] = '{8'h08, 3'd3, 8'h0F, 24'h000688};
        sweep[4] = '{8'h10, 3'd4, 8'h1F, 24'h004688};
        sweep[5] = '{8'h20, 3'd5, 8'h3F, 24'h02C688};
        sweep[6] = '{8'h40, 3'd6, 8'h7F, 24'h1AC688};
        sweep[7] = '{8'h80, 3'd7, 8'hFF, 24'hFAC688};

        reset    = 1'b0;
        selector = '0;
        data_in  = '0;
        switches = '0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b1;

        // Glitch: 0x04 for 2 cycles, then 0x08; only slot 3 lands, at edge 2+SETTLE.
        selector = 8'h04;
        data_in  = 3'd5;
        tick(2);
        selector = 8'h08;
        data_in  = 3'd6;
        tick(1 + SETTLE);
        check("glitch_early_data", 32'(section_data), 32'h0);
        check("glitch_early_valid", 32'(valid_sections), 32'h0);
        tick(1);
        check("glitch_data", 32'(section_data), 32'h000C00);
        check("glitch_valid", 32'(valid_sections), 32'h08);
        tick(14);
        check("glitch_no_frame", 32'(frames), 32'd0);

        foreach (sweep[i]) begin
            selector = sweep[i].sel;
            data_in  = sweep[i].din;
            tick(20);
            check($sformatf("sweep%0d_valid", i), 32'(valid_sections), 32'(sweep[i].exp_valid));
            check($sformatf("sweep%0d_data", i), 32'(section_data), 32'(sweep[i].exp_data));
        end
        check("sweep_frames", 32'(frames), 32'd1);

        // Multi-hot selector: error, no capture; next good capture clears it.
        selector = 8'h05;
        data_in  = 3'd7;
        tick(20);
        check("multi_err", 32'(sel_error), 32'h1);
        check("multi_data", 32'(section_data), 32'hFAC688);
        selector = 8'h01;
        data_in  = 3'd2;
        tick(1 + SETTLE);
        check("multi_err_held", 32'(sel_error), 32'h1);
        tick(1);
        check("multi_err_clear", 32'(sel_error), 32'h0);
        check("multi_recap_data", 32'(section_data), 32'hFAC68A);
        check("multi_frames", 32'(frames), 32'd1);

        // Bounce on switch 2 while section 2 is selected.
        selector = 8'h04;
        tick(20);
        check("bounce_start", 32'(data_switch), 32'h0);
        ones = 0;
        for (int k = 0; k < 12; k++) begin
            switches[2] = ~switches[2];
            for (int c = 0; c < 5; c++) begin
                tick(1);
                if (data_switch) ones++;
            end
        end
`ifdef SCAN_RESP_DEBOUNCE_EN
        check("bounce_quiet", 32'(ones), 32'd0);
`endif
        switches[2] = 1'b1;
        tick(DEB_LAT + 2);
        check("bounce_before", 32'(data_switch), 32'h0);
        tick(1);
        check("bounce_after", 32'(data_switch), 32'h1);

        // Selector change reaches data_switch after 3 edges.
        selector = 8'h01;
        tick(2);
        check("sel_lat_before", 32'(data_switch), 32'h1);
        tick(1);
        check("sel_lat_after", 32'(data_switch), 32'h0);

        // Timeout: last capture was 6 edges after the 0x01 change.
        tick(10);
        selector = 8'h00;
        tick(10);
        check("pre_stale", 32'(stale), 32'h0);
        n = 0;
        while (!stale && n < int'(TIMEOUT) + 20) begin
            tick(1);
            n++;
        end
        check("stale_set", 32'(stale), 32'h1);
        check("stale_time", 32'(n), TIMEOUT - 17);
        check("stale_valid", 32'(valid_sections), 32'h0);
        check("stale_data_kept", 32'(section_data), 32'hFAC68A);

        selector = 8'h02;
        data_in  = 3'd5;
        tick(1 + SETTLE);
        check("stale_held", 32'(stale), 32'h1);
        tick(1);
        check("stale_clear", 32'(stale), 32'h0);
        check("stale_recap_valid", 32'(valid_sections), 32'h02);
        check("stale_recap_data", 32'(section_data), 32'hFAC6AA);

        // Reset during SETTLE clears everything; no partial capture survives.
        tick(10);
        selector = 8'h10;
        data_in  = 3'd1;
        tick(4);
        reset = 1'b0;
        tick(1);
        check_all_zero("midreset");
        reset    = 1'b1;
        selector = 8'h00;
        tick(10);
        check("post_reset_data", 32'(section_data), 32'h0);
        check("post_reset_valid", 32'(valid_sections), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/scan_responder.md
# scan_responder

Panel-side end of the eight-section scan interface. It watches the one-hot section selector and the 3-bit section data that the scan driver multiplexes out, and demultiplexes them into eight held section registers. For the section currently selected, it returns the debounced state of that section's switch on `data_switch`. It sits on the panel board between the scan cable and the local LED and switch hardware.

## Interface
Parameters:
- `N_SECT`, 8: number of sections; width of `selector` and `switches`.
- `DATA_W`, 3: bits of data per section.
- `SETTLE`, 4: cycles the synchronized selector must hold steady before a capture.
- `DEB_CNT`, 16: consecutive disagreeing samples needed before a debounced switch flips.
- `TIMEOUT`, 65535: cycles with no capture before the link is declared stale.

Ports:
- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-low; 0 at a rising `clk` resets the block.
- `selector`, in, `N_SECT`: one-hot section select from the scan cable; asynchronous to `clk`.
- `data_in`, in, `DATA_W`: section data from the scan cable; asynchronous to `clk`.
- `switches`, in, `N_SECT`: raw local switch contacts.
- `data_switch`, out, 1: debounced switch state of the currently selected section.
- `section_data`, out, `N_SECT*DATA_W`: held data; section i occupies bits [i*DATA_W +: DATA_W].
- `valid_sections`, out, `N_SECT`: bit i is set once section i has been captured since reset or since the last stale event.
- `frame_done`, out, 1: one-cycle pulse, asserted when section `N_SECT-1` is captured while all valid bits are set.
- `sel_error`, out, 1: sticky; set by a stable multi-hot selector, cleared by the next good capture.
- `stale`, out, 1: set on timeout, cleared by the next capture.

## Operation
- **Input synchronization:** `selector` and `data_in` pass through two-flop synchronizers; all logic below uses the synchronized values.
- **State machine:** one FSM with states IDLE, SETTLE, HOLD and ERROR; reset state is IDLE.
  - IDLE: synchronized selector is zero. Go to SETTLE on any nonzero selector.
  - SETTLE: a counter clears whenever the selector changes value and increments otherwise.
    - Selector returns to zero: go to IDLE.
    - Counter reaches `SETTLE-1` with a one-hot selector: capture `data_in` into slot `idx`, set `valid_sections[idx]`, clear `sel_error` and `stale`, go to HOLD.
    - Counter reaches `SETTLE-1` with a multi-hot selector: set `sel_error`, go to ERROR.
  - HOLD and ERROR: stay until the selector changes. On a change to a nonzero value go to SETTLE; on a change to zero go to IDLE.
- **Stale timeout:**
  - The timeout counter clears on every capture and saturates at `TIMEOUT`.
  - When it reaches `TIMEOUT`, `stale` goes to 1 and `valid_sections` clears.
  - `section_data` keeps its last values.
- **Switch return path:**
  - `data_switch` is registered; it equals the debounced switch of the lowest set bit of the synchronized selector.
  - It is 0 when the selector is zero.
- **Boundary rules:**
  - A capture and a timeout in the same cycle: the capture wins.
  - `data_in` changing during SETTLE does not restart the counter; the value sampled on the capture cycle is stored.
  - Only a selector change restarts SETTLE.

## Timing
- **Reset values:** every output, every section register, every debounced switch, the FSM (IDLE) and all counters are 0.
- **Reset mid-operation:** all of the above clear on that edge; no partial capture survives.
- **Capture latency:** a raw `selector` change updates `section_data` at edge 2+`SETTLE`.
- **Switch return latency:**
  - Raw selector change to `data_switch` update: 3 cycles.
  - Raw switch edge to `data_switch` update: `DEB_CNT`+3 cycles (2 sync + `DEB_CNT` debounce + 1 output register).
- `frame_done` is asserted in the same cycle as the capture of section `N_SECT-1`.

## Configuration
- Macro: `SCAN_RESP_DEBOUNCE_EN`.
  - Defined: each switch passes through a 2-flop synchronizer, then a `DEB_CNT` debouncer.
  - Undefined: 2-flop synchronizer only; the debouncers are not instantiated and `DEB_CNT` is ignored.

## Structure
- **Package `scan_pkg`:**
  - `N_SECT` and `DATA_W` defaults.
  - FSM state typedef `scan_state_t` with encodings IDLE=0, SETTLE=1, HOLD=2, ERROR=3.
  - One-hot-check and index-encode functions.
- **Sub-module `switch_debounce`:** one instance per switch. It contains the 2-flop synchronizer, the saturating counter and the stable output.

## Test plan
- **Scan sweep:** drive selectors 0x01..0x80, each held 20 cycles, with `data_in` = i.
  - Required: `section_data` = 0xFAC688, `valid_sections` = 0xFF, and exactly one `frame_done` pulse.
- **Glitch:** selector 0x04 held 2 cycles, then 0x08 held 20 cycles.
  - Required: only slot 3 is captured.
  - Required: capture happens `SETTLE` cycles after the second change is synchronized.
- **Multi-hot:** selector 0x05 held 20 cycles.
  - Required: `sel_error` = 1 and no capture.
  - Then selector 0x01: `sel_error` returns to 0 after the capture.
- **Bounce:** `switches[2]` toggled every 5 cycles for 60 cycles, then held at 1; selector 0x04.
  - Required: `data_switch` stays 0 during bouncing.
  - Required: `data_switch` = 1 exactly `DEB_CNT`+3 cycles after the last edge.
- **Timeout and reset:**
  - Selector 0x00 for `TIMEOUT` cycles: `stale` = 1 and `valid_sections` = 0.
  - `reset` = 0 for 1 cycle during SETTLE: all outputs 0 on the next edge.
